// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Optional MULDIV_EARLY_OUT_EN: trivial ops (div by zero, signed overflow, multiply by zero) go straight to DONE.
module muldiv_unit #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  input  logic [OPCODE_LENGTH-1:0] Operation,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    Result,
  output logic                     busy
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t                    state, state_nxt;
  logic [CW-1:0]             counter;
  logic [DATA_WIDTH-1:0]     hi, lo, mcand;
  logic [2:0]                op;
  logic                      sign_a, sign_b;

  logic                      accept, early_hit;
  logic                      a_signed, b_signed, in_sa, in_sb;
  logic [DATA_WIDTH-1:0]     abs_a, abs_b;
  logic [DATA_WIDTH:0]       mul_sum, div_shift;
  logic [DATA_WIDTH-1:0]     div_diff;
  logic                      div_ge;
  logic [2*DATA_WIDTH-1:0]   product, prod_s;
  logic [DATA_WIDTH-1:0]     quo_s, rem_s, fix_result;

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid & in_ready & ~flush;

  assign a_signed = (Operation[2:0] == 3'b001) | (Operation[2:0] == 3'b010) |
                    (Operation[2:0] == 3'b100) | (Operation[2:0] == 3'b110);
  assign b_signed = (Operation[2:0] == 3'b001) | (Operation[2:0] == 3'b100) |
                    (Operation[2:0] == 3'b110);
  assign in_sa    = a_signed & SrcA[DATA_WIDTH-1];
  assign in_sb    = b_signed & SrcB[DATA_WIDTH-1];
  assign abs_a    = in_sa ? -SrcA : SrcA;
  assign abs_b    = in_sb ? -SrcB : SrcB;

`ifdef MULDIV_EARLY_OUT_EN
  localparam logic [DATA_WIDTH-1:0] MIN_VAL = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  logic                  early_div0, early_ovf, early_mzero;
  logic [DATA_WIDTH-1:0] early_result;
  assign early_div0   = Operation[2] & (SrcB == '0);
  assign early_ovf    = Operation[2] & ~Operation[0] & (SrcA == MIN_VAL) & (SrcB == '1);
  assign early_mzero  = ~Operation[2] & ((SrcA == '0) | (SrcB == '0));
  assign early_hit    = early_div0 | early_ovf | early_mzero;
  assign early_result = early_div0 ? (Operation[1] ? SrcA : '1) :
                        early_ovf  ? (Operation[1] ? '0 : MIN_VAL) : '0;
`else
  assign early_hit = 1'b0;
`endif

  // Multiply keeps {hi,lo} as the product accumulator with the multiplier in lo;
  // divide keeps the partial remainder in hi and shifts quotient bits into lo.
  assign mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
  assign div_shift = {hi, lo[DATA_WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, mcand};
  assign div_diff  = div_shift[DATA_WIDTH-1:0] - mcand;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = early_hit ? DONE : CALC;
      CALC:    if (counter == LAST) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter <= '0;
      hi      <= '0;
      lo      <= '0;
      mcand   <= '0;
      op      <= '0;
      sign_a  <= 1'b0;
      sign_b  <= 1'b0;
      Result  <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          counter <= '0;
          hi      <= '0;
          op      <= Operation[2:0];
          sign_a  <= in_sa;
          sign_b  <= in_sb;
          lo      <= Operation[2] ? abs_a : abs_b;
          mcand   <= Operation[2] ? abs_b : abs_a;
`ifdef MULDIV_EARLY_OUT_EN
          if (early_hit) Result <= early_result;
`endif
        end
        CALC: begin
          counter <= counter + 1'b1;
          if (op[2]) begin
            hi <= div_ge ? div_diff : div_shift[DATA_WIDTH-1:0];
            lo <= {lo[DATA_WIDTH-2:0], div_ge};
          end else begin
            hi <= mul_sum[DATA_WIDTH:1];
            lo <= {mul_sum[0], lo[DATA_WIDTH-1:1]};
          end
        end
        FIX:     Result <= fix_result;
        default: ;
      endcase
    end
  end

  // Divide by zero must give an all-ones quotient regardless of the dividend's sign.
  always_comb begin
    product    = {hi, lo};
    prod_s     = (sign_a ^ sign_b) ? -product : product;
    quo_s      = (mcand == '0) ? '1 : ((sign_a ^ sign_b) ? -lo : lo);
    rem_s      = sign_a ? -hi : hi;
    fix_result = '0;
    case (op)
      3'b000:                 fix_result = prod_s[DATA_WIDTH-1:0];
      3'b001, 3'b010, 3'b011: fix_result = prod_s[2*DATA_WIDTH-1:DATA_WIDTH];
      3'b100, 3'b101:         fix_result = quo_s;
      default:                fix_result = rem_s;
    endcase
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases plus randomized ops
// against an arithmetic reference model; honours MULDIV_EARLY_OUT_EN for latency.
module tb_muldiv_unit;

  localparam int W = 32;
  localparam logic [31:0] MIN = 32'h8000_0000;
`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY_EN = 1'b1;
`else
  localparam bit EARLY_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [W-1:0]  SrcA, SrcB, Result;
  logic [2:0]    Operation;

  int vectorCount = 0;
  int miscompareCount = 0;

  muldiv_unit #(.DATA_WIDTH(W), .OPCODE_LENGTH(3)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation), .out_valid(out_valid),
    .out_ready(out_ready), .Result(Result), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      miscompareCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [31:0] refModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p;
    logic [63:0] pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    pu = {32'b0, a} * {32'b0, b};
    case (op)
      3'd0: return pu[31:0];
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
      3'd3: return pu[63:32];
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MIN && b == 32'hFFFF_FFFF) return MIN;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == MIN && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int expLatency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bit special;
    if (op[2]) special = (b == 0) || (!op[0] && a == MIN && b == 32'hFFFF_FFFF);
    else       special = (a == 0) || (b == 0);
    return (EARLY_EN && special) ? 1 : W + 2;
  endfunction

  // One full transaction; holdCycles keeps out_ready low in DONE while checking stability.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               input int holdCycles, output logic [31:0] res, output int lat);
    int guard = 0;
    while (!in_ready && guard < 100) begin @(negedge clk); guard++; end
    if (!in_ready) checkOutput("ready_timeout", {63'b0, in_ready}, 64'd1);
    @(negedge clk);
    Operation = op; SrcA = a; SrcB = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    SrcA = $urandom; SrcB = $urandom; Operation = 3'($urandom);
    lat = 1;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    if (!out_valid) checkOutput("done_timeout", {63'b0, out_valid}, 64'd1);
    res = Result;
    for (int i = 0; i < holdCycles; i++) begin
      @(posedge clk); #1;
      checkOutput("hold_result", Result, res);
      checkOutput("hold_valid", {63'b0, out_valid}, 64'd1);
      checkOutput("hold_in_ready", {63'b0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] res, a, b;
    logic [2:0]  op;
    int lat, sel;
    bit seen;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    SrcA = '0; SrcB = '0; Operation = '0;
    #2;
    checkOutput("reset_out_valid", {63'b0, out_valid}, 64'd0);
    checkOutput("reset_busy", {63'b0, busy}, 64'd0);
    checkOutput("reset_result", Result, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 checkOutput("reset_in_ready", {63'b0, in_ready}, 64'd1);

    applyStimulus(3'd0, 32'hFFFF_FFFF, 32'd7, 0, res, lat);
    checkOutput("mul", res, 32'hFFFF_FFF9);
    checkOutput("mul_latency", lat, 34);
    checkOutput("idle_after_take", {63'b0, in_ready}, 64'd1);
    checkOutput("valid_after_take", {63'b0, out_valid}, 64'd0);
    applyStimulus(3'd1, 32'hFFFF_FFFF, 32'd7, 0, res, lat);
    checkOutput("mulh", res, 32'hFFFF_FFFF);
    applyStimulus(3'd3, 32'hFFFF_FFFF, 32'd7, 0, res, lat);
    checkOutput("mulhu", res, 32'h0000_0006);
    applyStimulus(3'd4, -32'sd7, 32'd2, 0, res, lat);
    checkOutput("div", res, 32'hFFFF_FFFD);
    applyStimulus(3'd6, -32'sd7, 32'd2, 0, res, lat);
    checkOutput("rem", res, 32'hFFFF_FFFF);
    applyStimulus(3'd5, 32'd100, 32'd7, 0, res, lat);
    checkOutput("divu", res, 32'd14);
    applyStimulus(3'd7, 32'd100, 32'd7, 0, res, lat);
    checkOutput("remu", res, 32'd2);

    applyStimulus(3'd4, 32'd5, 32'd0, 0, res, lat);
    checkOutput("div_by_zero", res, 32'hFFFF_FFFF);
    checkOutput("div0_latency", lat, EARLY_EN ? 1 : 34);
    applyStimulus(3'd6, 32'd5, 32'd0, 0, res, lat);
    checkOutput("rem_by_zero", res, 32'd5);
    applyStimulus(3'd4, MIN, 32'hFFFF_FFFF, 0, res, lat);
    checkOutput("div_overflow", res, MIN);
    checkOutput("ovf_latency", lat, EARLY_EN ? 1 : 34);
    applyStimulus(3'd6, MIN, 32'hFFFF_FFFF, 0, res, lat);
    checkOutput("rem_overflow", res, 32'd0);
    applyStimulus(3'd4, -32'sd9, 32'd0, 0, res, lat);
    checkOutput("div_neg_by_zero", res, 32'hFFFF_FFFF);

    applyStimulus(3'd2, -32'sd5, 32'd3, 10, res, lat);
    checkOutput("backpressure_mulhsu", res, 32'hFFFF_FFFF);

    // Flush mid-CALC
    @(negedge clk);
    Operation = 3'd0; SrcA = 32'd1234; SrcB = 32'd5678; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (15) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    checkOutput("flush_busy", {63'b0, busy}, 64'd0);
    checkOutput("flush_in_ready", {63'b0, in_ready}, 64'd1);
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1 if (out_valid) seen = 1'b1; end
    checkOutput("flush_no_valid", {63'b0, seen}, 64'd0);
    applyStimulus(3'd2, -32'sd2, 32'd3, 0, res, lat);
    checkOutput("mulhsu_after_flush", res, 32'hFFFF_FFFF);

    // flush beats in_valid in IDLE
    @(negedge clk);
    Operation = 3'd0; SrcA = 32'd3; SrcB = 32'd4; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0; flush = 1'b0;
    checkOutput("flush_vs_accept", {63'b0, busy}, 64'd0);

    // Async reset mid-CALC
    @(negedge clk);
    Operation = 3'd5; SrcA = 32'd1000; SrcB = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_valid", {63'b0, out_valid}, 64'd0);
    checkOutput("rst_mid_busy", {63'b0, busy}, 64'd0);
    checkOutput("rst_mid_result", Result, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    #1 checkOutput("rst_release_ready", {63'b0, in_ready}, 64'd1);

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      sel = $urandom_range(0, 9);
      a = $urandom; b = $urandom;
      case (sel)
        0: b = 32'd0;
        1: begin a = MIN; b = 32'hFFFF_FFFF; end
        2: a = 32'd0;
        3: begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
        4: begin a = -$urandom_range(0, 300); b = -$urandom_range(1, 20); end
        default: ;
      endcase
      applyStimulus(op, a, b, $urandom_range(0, 2), res, lat);
      checkOutput($sformatf("rand%0d_op%0d_result", i, op), res, refModel(op, a, b));
      checkOutput($sformatf("rand%0d_latency", i), lat, expLatency(op, a, b));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
    $finish;
  end

endmodule
